// File: rtl/da_pkg.sv
// Shared constants and elaboration-time helpers for the DA multiplier datapath.
// Used by the adder tree and its per-level stage module.
package da_pkg;

    localparam int DA_DSIZE = 10;
    localparam int DA_NUM   = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of elements entering tree level k when level 0 has n elements.
    function automatic int tree_count(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Bit used to widen a word by one position: copy of the MSB when signed, else 0.
    function automatic logic ext_bit(input logic msb, input bit is_signed);
        return is_signed ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/da_add_stage.sv
// One registered level of the adder tree: pairwise sums of N_IN words of IW bits,
// with an odd leftover word passed through, plus valid bit, tag and ready logic.
module da_add_stage
    import da_pkg::*;
#(
    parameter  int N_IN   = 2,
    parameter  int IW     = 10,
    parameter  int SIGNED = 0,
    parameter  int TSIZE  = 1,
    localparam int N_OUT  = (N_IN + 1) / 2,
    localparam int OW     = IW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*IW-1:0]    in_data,
    input  logic [TSIZE-1:0]      in_tag,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_OUT*OW-1:0]   out_data,
    output logic [TSIZE-1:0]      out_tag,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [N_OUT*OW-1:0] sum;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [IW-1:0] a;
        logic [OW-1:0] a_ext;

        assign a     = in_data[2*j*IW +: IW];
        assign a_ext = {ext_bit(a[IW-1], SIGNED != 0), a};

        if (2 * j + 1 < N_IN) begin : g_add
            logic [IW-1:0] b;
            logic [OW-1:0] b_ext;

            assign b     = in_data[(2*j+1)*IW +: IW];
            assign b_ext = {ext_bit(b[IW-1], SIGNED != 0), b};
            assign sum[j*OW +: OW] = a_ext + b_ext;
        end else begin : g_pass
            assign sum[j*OW +: OW] = a_ext;
        end
    end

    // Handshake: a sample moves across a boundary when valid and ready are both high
    // on a rising edge. This stage can load whenever it is empty or its content leaves
    // in the same cycle, so bubbles collapse while the output is stalled.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= sum;
                out_tag  <= in_tag;
            end
        end
    end

endmodule

// File: rtl/da_adder_tree.sv
// Pipelined adder tree reducing NUM packed DSIZE-bit words to one full-precision sum,
// one register level per tree level, with valid/ready flow control and a sideband tag.
module da_adder_tree
    import da_pkg::*;
#(
    parameter  int DSIZE  = DA_DSIZE,
    parameter  int NUM    = DA_NUM,
    parameter  int SIGNED = 0,
    parameter  int TSIZE  = 1,
    localparam int STAGES = (clog2(NUM) < 1) ? 1 : clog2(NUM),
    localparam int OSIZE  = DSIZE + clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM*DSIZE-1:0] in_data,
    input  logic [TSIZE-1:0]     in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OSIZE-1:0]     out_data,
    output logic [TSIZE-1:0]     out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    if (NUM < 1 || DSIZE < 1) begin : g_param_check
        $error("da_adder_tree: NUM and DSIZE must both be at least 1");
    end

    // rdy[k] is the load enable of level k; the chain runs from the output back to in_ready.
    logic [STAGES:0] rdy;

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int N_IN  = tree_count(NUM, k);
        localparam int IW    = DSIZE + k;
        localparam int N_OUT = (N_IN + 1) / 2;
        localparam int OW    = IW + 1;

        logic [N_IN*IW-1:0]   d_in;
        logic [TSIZE-1:0]     t_in;
        logic                 v_in;
        logic [N_OUT*OW-1:0]  q_data;
        logic [TSIZE-1:0]     q_tag;
        logic                 q_valid;

        if (k == 0) begin : g_src
            assign d_in = in_data;
            assign t_in = in_tag;
            assign v_in = in_valid;
        end else begin : g_src
            assign d_in = g_lvl[k-1].q_data;
            assign t_in = g_lvl[k-1].q_tag;
            assign v_in = g_lvl[k-1].q_valid;
        end

        da_add_stage #(
            .N_IN   (N_IN),
            .IW     (IW),
            .SIGNED (SIGNED),
            .TSIZE  (TSIZE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_data   (d_in),
            .in_tag    (t_in),
            .in_valid  (v_in),
            .in_ready  (rdy[k]),
            .out_data  (q_data),
            .out_tag   (q_tag),
            .out_valid (q_valid),
            .out_ready (rdy[k+1])
        );
    end

    // The last level is DSIZE+STAGES wide; only NUM=1 carries one spare extension bit,
    // which is a pure copy/zero and can be dropped without loss.
    assign out_data  = g_lvl[STAGES-1].q_data[OSIZE-1:0];
    assign out_tag   = g_lvl[STAGES-1].q_tag;
    assign out_valid = g_lvl[STAGES-1].q_valid;

endmodule

// File: tb/tb_da_adder_tree.sv
// Directed bench for da_adder_tree across several parameter sets: sums, latency,
// streaming, backpressure, reset while busy, and a randomised NUM=1 run.
module tb_da_adder_tree;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // A: DSIZE=10 NUM=5 unsigned
    logic [49:0]  a_in_data;
    logic         a_in_tag, a_in_valid, a_in_ready, a_out_tag, a_out_valid, a_out_ready;
    logic [12:0]  a_out_data;
    // B: DSIZE=4 NUM=5 signed
    logic [19:0]  b_in_data;
    logic         b_in_tag, b_in_valid, b_in_ready, b_out_tag, b_out_valid, b_out_ready;
    logic [6:0]   b_out_data;
    // C: DSIZE=10 NUM=10, 8-bit tag
    logic [99:0]  c_in_data;
    logic [7:0]   c_in_tag, c_out_tag;
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [13:0]  c_out_data;
    // D: DSIZE=10 NUM=8, 8-bit tag
    logic [79:0]  d_in_data;
    logic [7:0]   d_in_tag, d_out_tag;
    logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [12:0]  d_out_data;
    // E: DSIZE=10 NUM=1
    logic [9:0]   e_in_data, e_out_data;
    logic         e_in_tag, e_in_valid, e_in_ready, e_out_tag, e_out_valid, e_out_ready;

    da_adder_tree #(.DSIZE(10), .NUM(5), .SIGNED(0), .TSIZE(1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_tag(a_in_tag), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_tag(a_out_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready));

    da_adder_tree #(.DSIZE(4), .NUM(5), .SIGNED(1), .TSIZE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_tag(b_in_tag), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_tag(b_out_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready));

    da_adder_tree #(.DSIZE(10), .NUM(10), .SIGNED(0), .TSIZE(8)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_tag(c_in_tag), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_tag(c_out_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    da_adder_tree #(.DSIZE(10), .NUM(8), .SIGNED(0), .TSIZE(8)) u_d (
        .clk(clk), .rst(rst), .in_data(d_in_data), .in_tag(d_in_tag), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_tag(d_out_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready));

    da_adder_tree #(.DSIZE(10), .NUM(1), .SIGNED(0), .TSIZE(1)) u_e (
        .clk(clk), .rst(rst), .in_data(e_in_data), .in_tag(e_in_tag), .in_valid(e_in_valid),
        .in_ready(e_in_ready), .out_data(e_out_data), .out_tag(e_out_tag),
        .out_valid(e_out_valid), .out_ready(e_out_ready));

    logic [13:0] exp_q[$];
    logic [7:0]  tag_q[$];
    logic [9:0]  e_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lat;
        int s;
        int nd;
        int stale;
        int pushed;
        int popped;
        int cyc;
        bit e_took;

        a_in_data = '0; a_in_tag = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_tag = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_tag = '0;   c_in_valid = 1'b0; c_out_ready = 1'b1;
        d_in_data = '0; d_in_tag = '0;   d_in_valid = 1'b0; d_out_ready = 1'b1;
        e_in_data = '0; e_in_tag = 1'b0; e_in_valid = 1'b0; e_out_ready = 1'b1;

        // ---- reset state
        @(negedge clk);
        chk("rst_a_out_valid", a_out_valid, 1'b0);
        chk("rst_a_out_data", a_out_data, 13'd0);
        chk("rst_a_in_ready", a_in_ready, 1'b1);
        chk("rst_c_out_tag", c_out_tag, 8'd0);
        chk("rst_d_in_ready", d_in_ready, 1'b1);
        chk("rst_e_out_valid", e_out_valid, 1'b0);
        rst = 1'b0;

        // ---- unsigned max, NUM=5: 5*1023 = 5115, latency 3
        a_in_data  = {5{10'h3FF}};
        a_in_valid = 1'b1;
        chk("a_in_ready", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("a_latency", lat, 3);
        chk("a_sum_max", a_out_data, 13'd5115);
        @(negedge clk);
        chk("a_valid_drop", a_out_valid, 1'b0);

        // ---- signed, NUM=5 DSIZE=4: all -8 -> -40; {7,-8,3,-1,0} -> +1
        b_in_data  = {5{4'h8}};
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_data  = {4'h0, 4'hF, 4'h3, 4'h8, 4'h7};
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_min_valid", b_out_valid, 1'b1);
        chk("b_min_sum", b_out_data, 7'h58);
        @(negedge clk);
        chk("b_mix_valid", b_out_valid, 1'b1);
        chk("b_mix_sum", b_out_data, 7'h01);
        @(negedge clk);
        chk("b_valid_drop", b_out_valid, 1'b0);

        // ---- streaming, NUM=10 (4 stages): sample i -> 10*i, tag i, no gaps
        for (int c = 0; c < 30; c++) begin
            if (c >= 4 && c < 24) begin
                chk("c_stream_valid", c_out_valid, 1'b1);
                chk("c_stream_data", c_out_data, 14'(10 * (c - 4)));
                chk("c_stream_tag", c_out_tag, 8'(c - 4));
            end else begin
                chk("c_stream_idle", c_out_valid, 1'b0);
            end
            if (c < 20) begin
                c_in_valid = 1'b1;
                c_in_tag   = 8'(c);
                for (int w = 0; w < 10; w++) c_in_data[w*10 +: 10] = 10'(c);
                chk("c_stream_in_ready", c_in_ready, 1'b1);
            end else begin
                c_in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // ---- backpressure, NUM=8 (3 stages): capacity 3, held output, ordered drain
        d_out_ready = 1'b0;
        s = 0;
        while (s < 6) begin
            d_in_valid = 1'b1;
            d_in_tag   = 8'(s);
            for (int w = 0; w < 8; w++) d_in_data[w*10 +: 10] = 10'(s + 1);
            #1;
            if (!d_in_ready) break;
            exp_q.push_back(14'(8 * (s + 1)));
            tag_q.push_back(8'(s));
            s++;
            @(negedge clk);
        end
        chk("d_accept_count", s, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("d_stall_in_ready", d_in_ready, 1'b0);
            chk("d_stall_valid", d_out_valid, 1'b1);
            chk("d_stall_data", d_out_data, 13'd8);
            chk("d_stall_tag", d_out_tag, 8'd0);
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            if (d_out_valid) begin
                nd++;
                if (exp_q.size() > 0) begin
                    chk("d_drain_data", d_out_data, exp_q.pop_front());
                    chk("d_drain_tag", d_out_tag, tag_q.pop_front());
                end else begin
                    chk("d_drain_extra", d_out_valid, 1'b0);
                end
            end
            @(negedge clk);
        end
        chk("d_drain_count", nd, 3);

        // ---- reset while two samples sit in the NUM=10 pipe
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_tag    = 8'd5;
        for (int w = 0; w < 10; w++) c_in_data[w*10 +: 10] = 10'd5;
        @(negedge clk);
        c_in_tag    = 8'd6;
        for (int w = 0; w < 10; w++) c_in_data[w*10 +: 10] = 10'd6;
        @(negedge clk);
        c_in_valid  = 1'b0;
        repeat (4) @(negedge clk);
        chk("c_prerst_valid", c_out_valid, 1'b1);
        chk("c_prerst_data", c_out_data, 14'd50);
        rst = 1'b1;
        #1;
        chk("c_rst_valid", c_out_valid, 1'b0);
        chk("c_rst_data", c_out_data, 14'd0);
        chk("c_rst_tag", c_out_tag, 8'd0);
        chk("c_rst_in_ready", c_in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        c_out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (c_out_valid) stale++;
            @(negedge clk);
        end
        chk("c_no_stale", stale, 0);
        c_in_valid = 1'b1;
        c_in_tag   = 8'd9;
        for (int w = 0; w < 10; w++) c_in_data[w*10 +: 10] = 10'd1;
        @(negedge clk);
        c_in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("c_post_latency", lat, 4);
        chk("c_post_data", c_out_data, 14'd10);
        chk("c_post_tag", c_out_tag, 8'd9);

        // ---- NUM=1: pass-through with one register
        e_in_data  = 10'h3FF;
        e_in_valid = 1'b1;
        @(negedge clk);
        e_in_valid = 1'b0;
        chk("e_valid", e_out_valid, 1'b1);
        chk("e_data", e_out_data, 10'h3FF);
        @(negedge clk);
        chk("e_valid_drop", e_out_valid, 1'b0);

        // ---- NUM=1 random traffic against a reference queue
        pushed = 0;
        popped = 0;
        cyc    = 0;
        e_took = 1'b0;
        while (popped < 1000 && cyc < 20000) begin
            if (!e_in_valid && pushed < 1000) begin
                e_in_valid = ($urandom_range(0, 3) != 0);
                e_in_data  = 10'($urandom_range(0, 1023));
            end
            e_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (e_out_valid && e_out_ready) begin
                if (e_q.size() > 0) chk("e_rand_data", e_out_data, e_q.pop_front());
                else chk("e_rand_spurious", e_out_valid, 1'b0);
                popped++;
            end
            e_took = e_in_valid && e_in_ready;
            if (e_took) begin
                e_q.push_back(e_in_data);
                pushed++;
            end
            @(negedge clk);
            if (e_took) e_in_valid = 1'b0;
            cyc++;
        end
        chk("e_rand_count", popped, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
